// File: rtl/upgrade_spawner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : upgrade_spawner_pkg
// Brief    : Shared game types, screen constants and spawner helper functions.
// Revision : 1.0
// ============================================================================
package upgrade_spawner_pkg;

  typedef logic [9:0] coord_t;

  typedef enum logic [1:0] {
    S_COOLDOWN = 2'd0,
    S_PICK     = 2'd1,
    S_ACTIVE   = 2'd2
  } spawn_state_t;

  localparam int          SCREEN_W  = 640;
  localparam int          SCREEN_H  = 480;
  localparam coord_t      PARK_XY   = 10'd1000;
  localparam coord_t      CENTER_X  = 10'(SCREEN_W / 2);
  localparam coord_t      CENTER_Y  = 10'(SCREEN_H / 2);
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  // Right-shifting Galois step; feedback applied when the bit shifted out is 1.
  function automatic logic [15:0] lfsr_step(input logic [15:0] q);
    return q[0] ? ((q >> 1) ^ LFSR_MASK) : (q >> 1);
  endfunction

  // True when the candidate centre is far enough from one ball on at least one axis.
  function automatic logic clear_of_ball(input coord_t cx, input coord_t cy,
                                         input coord_t bx, input coord_t by,
                                         input logic [10:0] keepout);
    logic signed [10:0] dx;
    logic signed [10:0] dy;
    logic        [10:0] adx;
    logic        [10:0] ady;
    dx  = $signed({1'b0, cx}) - $signed({1'b0, bx});
    dy  = $signed({1'b0, cy}) - $signed({1'b0, by});
    adx = dx[10] ? $unsigned(-dx) : $unsigned(dx);
    ady = dy[10] ? $unsigned(-dy) : $unsigned(dy);
    return (adx >= keepout) || (ady >= keepout);
  endfunction

endpackage
`default_nettype wire

// File: rtl/upgrade_spawner_if.sv
`default_nettype none
// ============================================================================
// Module   : upgrade_spawner_if
// Brief    : Pickup bus between the spawner and the pickup/attach consumer.
// Revision : 1.0
// ============================================================================
interface upgrade_spawner_if;
  import upgrade_spawner_pkg::*;

  coord_t UpgradeX;
  coord_t UpgradeY;
  coord_t Upgrade_Size;
  logic   upgrade_active;
  logic   respawn_pulse;
  logic   was_collected;

  modport master (
    output UpgradeX,
    output UpgradeY,
    output Upgrade_Size,
    output upgrade_active,
    output respawn_pulse,
    input  was_collected
  );

  modport slave (
    input  UpgradeX,
    input  UpgradeY,
    input  Upgrade_Size,
    input  upgrade_active,
    input  respawn_pulse,
    output was_collected
  );

endinterface
`default_nettype wire

// File: rtl/upgrade_spawner_lfsr16.sv
`default_nettype none
// ============================================================================
// Module   : upgrade_lfsr16
// Brief    : Free-running 16-bit Galois LFSR, reloaded with seed on reset.
// Revision : 1.0
// ============================================================================
module upgrade_lfsr16
  import upgrade_spawner_pkg::*;
(
  input  wire logic        frame_clk,
  input  wire logic        Reset,
  input  wire logic [15:0] seed,
  output logic      [15:0] q
);

  logic [15:0] r_q;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_q <= seed;
    end else begin
      r_q <= lfsr_step(r_q);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/upgrade_spawner.sv
`default_nettype none
// ============================================================================
// Module   : upgrade_spawner
// Brief    : Places the upgrade pickup clear of both players, times it out and
//            respawns it after a cooldown.
// Revision : 1.0
// ============================================================================
module upgrade_spawner
  import upgrade_spawner_pkg::*;
#(
  parameter int          INITIAL_DELAY = 120,
  parameter int          COOLDOWN      = 300,
  parameter int          LIFETIME      = 600,
  parameter int          UPG_SIZE      = 8,
  parameter int          X_MIN         = 16,
  parameter int          X_MAX         = SCREEN_W - 17,
  parameter int          Y_MIN         = 16,
  parameter int          Y_MAX         = SCREEN_H - 17,
  parameter int          KEEPOUT       = 48,
  parameter int          MAX_TRIES     = 15,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  wire logic       frame_clk,
  input  wire logic       Reset,
  input  wire logic [9:0] BallX,
  input  wire logic [9:0] BallY,
  input  wire logic [9:0] Ball2X,
  input  wire logic [9:0] Ball2Y,
  upgrade_spawner_if.master bus
);

  localparam logic [11:0] c_init_delay = 12'(INITIAL_DELAY);
  localparam logic [11:0] c_cooldown   = 12'(COOLDOWN);
  localparam logic [11:0] c_lifetime   = 12'(LIFETIME);
  localparam logic [3:0]  c_max_tries  = 4'(MAX_TRIES);
  localparam coord_t      c_upg_size   = 10'(UPG_SIZE);
  localparam coord_t      c_x_min      = 10'(X_MIN);
  localparam coord_t      c_x_max      = 10'(X_MAX);
  localparam coord_t      c_y_min      = 10'(Y_MIN);
  localparam coord_t      c_y_max      = 10'(Y_MAX);
  localparam logic [10:0] c_keepout    = 11'(KEEPOUT);

  spawn_state_t r_state;
  spawn_state_t w_state_next;
  logic [11:0]  r_timer;
  logic [11:0]  w_timer_next;
  logic [11:0]  w_timer_dec;
  logic [3:0]   r_tries;
  logic [3:0]   w_tries_next;
  logic         r_prev_wc;
  coord_t       r_upg_x;
  coord_t       r_upg_y;
  coord_t       w_upg_x_next;
  coord_t       w_upg_y_next;
  logic         r_active;
  logic         w_active_next;
  logic         r_pulse;
  logic         w_pulse_next;

  logic [15:0]  w_lfsr;
  coord_t       w_cx;
  coord_t       w_cy;
  logic         w_in_range;
  logic         w_clear_p1;
  logic         w_clear_p2;
  logic         w_legal;
  logic         w_coll_edge;

  upgrade_lfsr16 u_lfsr (
    .frame_clk (frame_clk),
    .Reset     (Reset),
    .seed      (LFSR_SEED),
    .q         (w_lfsr)
  );

  assign w_cx        = w_lfsr[9:0];
  assign w_cy        = w_lfsr[15:6];
  assign w_in_range  = (w_cx >= c_x_min) && (w_cx <= c_x_max) &&
                       (w_cy >= c_y_min) && (w_cy <= c_y_max);
  assign w_clear_p1  = clear_of_ball(w_cx, w_cy, BallX, BallY, c_keepout);
  assign w_clear_p2  = clear_of_ball(w_cx, w_cy, Ball2X, Ball2Y, c_keepout);
  assign w_legal     = w_in_range && w_clear_p1 && w_clear_p2;
  assign w_coll_edge = bus.was_collected & ~r_prev_wc;

  // Saturating decrement; a phase ends on the frame the decremented value hits zero.
  assign w_timer_dec = (r_timer == 12'd0) ? 12'd0 : (r_timer - 12'd1);

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state   <= S_COOLDOWN;
      r_timer   <= c_init_delay;
      r_tries   <= 4'd0;
      r_prev_wc <= 1'b0;
      r_upg_x   <= PARK_XY;
      r_upg_y   <= PARK_XY;
      r_active  <= 1'b0;
      r_pulse   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_tries   <= w_tries_next;
      r_prev_wc <= bus.was_collected;
      r_upg_x   <= w_upg_x_next;
      r_upg_y   <= w_upg_y_next;
      r_active  <= w_active_next;
      r_pulse   <= w_pulse_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = r_timer;
    w_tries_next  = r_tries;
    w_upg_x_next  = PARK_XY;
    w_upg_y_next  = PARK_XY;
    w_active_next = 1'b0;
    w_pulse_next  = 1'b0;

    case (r_state)
      S_COOLDOWN: begin
        w_timer_next = w_timer_dec;
        if (w_timer_dec == 12'd0) begin
          w_state_next = S_PICK;
          w_tries_next = 4'd0;
        end
      end

      S_PICK: begin
        if (w_legal || (r_tries == c_max_tries)) begin
          w_state_next  = S_ACTIVE;
          w_timer_next  = c_lifetime;
          w_active_next = 1'b1;
          w_pulse_next  = 1'b1;
          w_upg_x_next  = w_legal ? w_cx : CENTER_X;
          w_upg_y_next  = w_legal ? w_cy : CENTER_Y;
        end else begin
          w_tries_next = r_tries + 4'd1;
        end
      end

      S_ACTIVE: begin
        w_timer_next  = w_timer_dec;
        w_active_next = 1'b1;
        w_upg_x_next  = r_upg_x;
        w_upg_y_next  = r_upg_y;
        // Collection and expiry share one exit, so a coincident pair leaves once.
        if (w_coll_edge || (w_timer_dec == 12'd0)) begin
          w_state_next  = S_COOLDOWN;
          w_timer_next  = c_cooldown;
          w_active_next = 1'b0;
          w_upg_x_next  = PARK_XY;
          w_upg_y_next  = PARK_XY;
        end
      end

      default: begin
        w_state_next = S_COOLDOWN;
        w_timer_next = c_cooldown;
      end
    endcase
  end

  assign bus.UpgradeX       = r_upg_x;
  assign bus.UpgradeY       = r_upg_y;
  assign bus.Upgrade_Size   = c_upg_size;
  assign bus.upgrade_active = r_active;
  assign bus.respawn_pulse  = r_pulse;

endmodule
`default_nettype wire
